// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM among NREQ requesters.
// Each grant serves up to BURST reads; data returns one cycle after the address.
module sprite_rom_arbiter #(
    parameter int NREQ  = 4,
    parameter int AW    = 21,
    parameter int DW    = 5,
    parameter int BURST = 8
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*AW-1:0]         addr,
    output logic [NREQ-1:0]            gnt,
    output logic [AW-1:0]              rom_addr,
    input  logic [DW-1:0]              rom_data,
    output logic                       rd_valid,
    output logic [$clog2(NREQ)-1:0]    rd_id,
    output logic [DW-1:0]              rd_data,
    output logic                       busy
);

    // state   | meaning
    // S_IDLE  | no grant held, rom_addr driven to zero
    // S_GRANT | r_owner holds the ROM, one gnt bit high
    typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(BURST);

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic            r_rd_valid;
    logic [IW-1:0]   r_rd_id;

    logic            w_any;
    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_ptr_nxt;
    logic            w_accept;
    logic            w_release;
    logic            w_rearb;
    logic [AW-1:0]   w_owner_addr;

    // First requester at or above r_ptr, wrapping; the old owner sits last since r_ptr = owner+1.
    always_comb begin : p_arb
        logic [IW-1:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = IW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end
    end

    assign w_any        = |req;
    assign w_ptr_nxt    = (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    assign w_owner_addr = addr[r_owner*AW +: AW];
    assign w_accept     = (r_state == S_GRANT) && req[r_owner];
    assign w_release    = (r_state == S_GRANT) &&
                          (!req[r_owner] || (r_cnt == CW'(BURST - 1)));
    assign w_rearb      = (r_state == S_IDLE) || w_release;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_id    <= '0;
        end else begin
            r_rd_valid <= w_accept;
            if (w_accept) begin
                r_rd_id <= r_owner;
            end
            if (w_rearb) begin
                if (w_any) begin
                    r_state <= S_GRANT;
                    r_gnt   <= NREQ'(1) << w_win;
                    r_owner <= w_win;
                    r_ptr   <= w_ptr_nxt;
                    r_cnt   <= '0;
                end else begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_cnt   <= '0;
                end
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign gnt      = r_gnt;
    assign busy     = |r_gnt;
    assign rom_addr = (r_state == S_GRANT) ? w_owner_addr : '0;
    assign rd_valid = r_rd_valid;
    assign rd_id    = r_rd_id;
    assign rd_data  = rom_data;

endmodule
